// File: rtl/mux_sel_arbiter_if.sv
// mux_sel_arbiter_if
//   Bundles the request/grant/handshake signals between the four requesters,
//   the round-robin arbiter and the downstream mux4x1 consumer.
//   Signals:
//     req       [3:0]  request per source (bit i = source i)
//     req_mask  [3:0]  per-source request mask (only with ARB_MASK_EN defined)
//     out_ready        downstream accepts the current selection this cycle
//     sel       [1:0]  select presented to mux4x1
//     gnt       [3:0]  one-hot grant, zero when idle
//     out_valid        sel/gnt valid for transfer
//   Modports:
//     master  arbiter side (drives sel/gnt/out_valid)
//     slave   requester/consumer side (drives req/out_ready)
//   Optional macro: ARB_MASK_EN
interface mux_sel_arbiter_if;
  logic [3:0] req;
`ifdef ARB_MASK_EN
  logic [3:0] req_mask;
`endif
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;

`ifdef ARB_MASK_EN
  modport master (input req, input req_mask, input out_ready,
                  output sel, output gnt, output out_valid);
  modport slave  (output req, output req_mask, output out_ready,
                  input sel, input gnt, input out_valid);
`else
  modport master (input req, input out_ready,
                  output sel, output gnt, output out_valid);
  modport slave  (output req, output out_ready,
                  input sel, input gnt, input out_valid);
`endif
endinterface

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Four-way round-robin arbiter driving the 2-bit select of a mux4x1.
//   The winner's index is presented on sel with a one-hot gnt and held
//   stable until the consumer accepts (out_valid & out_ready). A requester
//   may keep the grant for up to MAX_BURST consecutive accepted transfers.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    mux_sel_arbiter_if.master (req, [req_mask], out_ready,
//            sel, gnt, out_valid)
//   Parameters:
//     MAX_BURST  consecutive accepted transfers per grant (1..15)
//     CNT_W      burst counter width (must hold MAX_BURST-1)
//   Optional macro: ARB_MASK_EN adds req_mask; effective request is
//     req & ~req_mask.
module mux_sel_arbiter #(
  parameter int MAX_BURST = 1,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_sel_arbiter_if.master bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  logic [0:0]       r_state;
  logic [1:0]       r_sel;
  logic [1:0]       r_last_ptr;
  logic [3:0]       r_gnt;
  logic             r_valid;
  logic [CNT_W-1:0] r_burst_cnt;

  logic [3:0]       w_req_eff;
  logic [1:0]       w_base;
  logic [1:0]       w_idx;
  logic [1:0]       w_win;
  logic             w_found;
  logic             w_keep;

`ifdef ARB_MASK_EN
  assign w_req_eff = bus.req & ~bus.req_mask;
`else
  assign w_req_eff = bus.req;
`endif

  // In GRANT the search base is sel (it becomes last_ptr on accept), so the
  // currently granted source is visited last and only wins when it is the
  // sole requester.
  always_comb begin
    w_base  = (r_state == GRANT) ? r_sel : r_last_ptr;
    w_found = 1'b0;
    w_win   = w_base;
    w_idx   = w_base;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = w_base + 2'(i);
      if (!w_found && w_req_eff[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_keep = w_req_eff[r_sel] && (r_burst_cnt < BURST_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_last_ptr  <= 2'd3;
      r_gnt       <= '0;
      r_valid     <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel       <= w_win;
            r_gnt       <= 4'b0001 << w_win;
            r_valid     <= 1'b1;
            r_burst_cnt <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          // Without an accept everything is frozen, regardless of req.
          if (bus.out_ready) begin
            r_last_ptr <= r_sel;
            if (w_keep) begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end else if (w_found) begin
              r_sel       <= w_win;
              r_gnt       <= 4'b0001 << w_win;
              r_burst_cnt <= '0;
            end else begin
              r_valid     <= 1'b0;
              r_gnt       <= '0;
              r_burst_cnt <= '0;
              r_state     <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.gnt       = r_gnt;
  assign bus.out_valid = r_valid;

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
Four-way round-robin arbiter that sits directly upstream of the 3-bit mux4x1 and drives its 2-bit select. Four requesters raise req; the arbiter picks one, presents its index on sel and a one-hot gnt, and holds both stable until the downstream consumer accepts via a valid/ready handshake. An optional burst limit lets one requester keep the grant for several consecutive transfers.

Parameters:
MAX_BURST, 1, max consecutive accepted transfers per grant before rotation (legal 1..15)
CNT_W, 4, width of internal burst counter (must hold MAX_BURST-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request per source; bit i = source i (mux input a(i+1))
out_ready  input  1  downstream accepts current selection this cycle
sel  output  2  registered select to mux4x1 sel
gnt  output  4  registered one-hot grant, 0 when idle
out_valid  output  1  registered; sel/gnt valid for transfer

Behaviour:
- Reset (async, rst_n=0): sel=2'b00, gnt=4'b0000, out_valid=0, last_ptr=3, burst_cnt=0, state=IDLE. Release is synchronous to clk; first arbitration on first rising edge with rst_n=1.
- Priority: search starts at last_ptr+1 mod 4, wraps 3->0; first set req bit wins. After reset source 0 has highest priority.
- States: IDLE, GRANT.
- IDLE: req==0 -> stay, outputs unchanged (sel keeps last value, gnt=0, out_valid=0). req!=0 -> next edge: winner w, sel=w, gnt=1<<w, out_valid=1, burst_cnt=0, state=GRANT. Latency req->out_valid: 1 cycle.
- GRANT, out_ready=0: sel, gnt, out_valid held stable; req changes (including drop of granted bit) ignored.
- GRANT, out_ready=1 (accept): last_ptr=sel.
  - If req[sel]=1 and burst_cnt < MAX_BURST-1: keep grant, burst_cnt++.
  - Else if any req bit set (search from sel+1, granted bit eligible only if it is the only one set): new winner on next edge, out_valid stays 1 (no bubble), burst_cnt=0.
  - Else: state=IDLE, out_valid=0, gnt=0, sel unchanged.
- One accept per cycle; throughput 1 transfer/cycle with continuous out_ready.
- MAX_BURST=1: pure round-robin, rotation after every accept.
- Reset mid-grant: outputs drop immediately (async), pending transfer discarded, priority restarts at source 0.
- gnt always one-hot or zero; gnt != 0 iff out_valid=1; when out_valid=1, gnt == 1<<sel.

Optional Feature:
ARB_MASK_EN: when defined, adds input req_mask [3:0]; effective request = req & ~req_mask for all arbitration and burst-continue decisions; mask does not revoke a grant already held (stability rule wins). When undefined, port absent and effective request = req.

Test Plan:
- Reset then req=4'b1111, out_ready=1, MAX_BURST=1 -> sel sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 from cycle 1 with no gaps.
- req=4'b0100, out_ready=0 for 3 cycles, then drop req -> sel=2, gnt=4'b0100 held all 3 cycles; accept on cycle 4, then out_valid=0, gnt=0, sel stays 2.
- last_ptr=2, req=4'b0011 -> winner sel=0 (wrap 3->0), then sel=1.
- MAX_BURST=3, req=4'b1001 constant, out_ready=1 -> sel 0,0,0,3,3,3,0...
- rst_n pulsed low while out_valid=1 with sel=3 -> out_valid, gnt go 0 asynchronously, sel=0; after release with req=4'b1000 -> sel=3 after 1 cycle.
- ARB_MASK_EN: req=4'b1111, req_mask=4'b0101, out_ready=1 -> sel alternates 1,3; masking source 1 while it is granted and stalled keeps gnt=4'b0010 until accept.
